// File: rtl/kronos_alu_arb.sv
// kronos_alu_arb: shares one combinational Kronos ALU between NUM_REQ requesters, round-robin,
// with a one-entry registered response. Define KRONOS_ALU_ARB_PRIO_EN to give requester 0 fixed priority.
module kronos_alu_arb #(
  parameter int NUM_REQ = 2,
  parameter int TAG_W   = 2
) (
  input  logic                     clk,
  input  logic                     rstz,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*32-1:0]    req_op1,
  input  logic [NUM_REQ*32-1:0]    req_op2,
  input  logic [NUM_REQ*4-1:0]     req_aluop,
  input  logic [NUM_REQ*TAG_W-1:0] req_tag,
  output logic [31:0]              alu_op1,
  output logic [31:0]              alu_op2,
  output logic [3:0]               alu_aluop,
  input  logic [31:0]              alu_result,
  output logic [NUM_REQ-1:0]       rsp_valid,
  input  logic [NUM_REQ-1:0]       rsp_ready,
  output logic [31:0]              rsp_result,
  output logic [TAG_W-1:0]         rsp_tag
);

  localparam int PTR_W = (NUM_REQ > 2) ? 2 : 1;
  localparam int IDX_W = PTR_W + 1;
  localparam logic [IDX_W-1:0] N_L = IDX_W'(NUM_REQ);
`ifdef KRONOS_ALU_ARB_PRIO_EN
  localparam logic [PTR_W-1:0] RR_RST = PTR_W'(1);
`else
  localparam logic [PTR_W-1:0] RR_RST = PTR_W'(0);
`endif

  logic [PTR_W-1:0] rr_ptr;
  logic [PTR_W-1:0] nxt_ptr;
  logic [PTR_W-1:0] gnt_idx;
  logic [IDX_W-1:0] scan;
  logic [IDX_W-1:0] ptr_inc;
  logic             any_vld;
  logic             arb_en;
  logic             free;
  logic             xfer;
  logic [TAG_W-1:0] gnt_tag;

  logic             vld_p1;
  logic [PTR_W-1:0] owner_p1;
  logic [31:0]      result_p1;
  logic [TAG_W-1:0] tag_p1;

  // Stage p0: arbitration and ALU operand drive
  always_comb begin
    gnt_idx = '0;
    any_vld = 1'b0;
    scan    = '0;
`ifdef KRONOS_ALU_ARB_PRIO_EN
    if (req_valid[0]) begin
      any_vld = 1'b1;
    end else begin
      // rr_ptr lives in 1..NUM_REQ-1, so the scan wraps back to 1, never 0
      for (int k = 0; k < NUM_REQ - 1; k++) begin
        scan = {1'b0, rr_ptr} + IDX_W'(k);
        if (scan >= N_L) scan = scan - N_L + IDX_W'(1);
        if (!any_vld && req_valid[scan[PTR_W-1:0]]) begin
          any_vld = 1'b1;
          gnt_idx = scan[PTR_W-1:0];
        end
      end
    end
`else
    for (int k = 0; k < NUM_REQ; k++) begin
      scan = {1'b0, rr_ptr} + IDX_W'(k);
      if (scan >= N_L) scan = scan - N_L;
      if (!any_vld && req_valid[scan[PTR_W-1:0]]) begin
        any_vld = 1'b1;
        gnt_idx = scan[PTR_W-1:0];
      end
    end
`endif
  end

  always_comb begin
    ptr_inc = {1'b0, gnt_idx} + IDX_W'(1);
    nxt_ptr = (ptr_inc == N_L) ? RR_RST : ptr_inc[PTR_W-1:0];
`ifdef KRONOS_ALU_ARB_PRIO_EN
    if (gnt_idx == '0) nxt_ptr = rr_ptr;
`endif
  end

  assign free = ~vld_p1 | rsp_ready[owner_p1];

  always_comb begin
    req_ready = '0;
    alu_op1   = '0;
    alu_op2   = '0;
    alu_aluop = '0;
    gnt_tag   = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (any_vld && (gnt_idx == PTR_W'(i))) begin
        req_ready[i] = arb_en & free;
        alu_op1      = req_op1[32*i +: 32];
        alu_op2      = req_op2[32*i +: 32];
        alu_aluop    = req_aluop[4*i +: 4];
        gnt_tag      = req_tag[TAG_W*i +: TAG_W];
      end
    end
  end

  assign xfer = |(req_valid & req_ready);

  // Stage p1: registered response
  always_ff @(posedge clk or negedge rstz) begin
    if (!rstz) begin
      arb_en    <= 1'b0;
      rr_ptr    <= RR_RST;
      vld_p1    <= 1'b0;
      owner_p1  <= '0;
      result_p1 <= '0;
      tag_p1    <= '0;
    end else begin
      arb_en <= 1'b1;
      if (xfer) begin
        vld_p1    <= 1'b1;
        owner_p1  <= gnt_idx;
        result_p1 <= alu_result;
        tag_p1    <= gnt_tag;
        rr_ptr    <= nxt_ptr;
      end else if (vld_p1 && rsp_ready[owner_p1]) begin
        vld_p1 <= 1'b0;
      end
    end
  end

  always_comb begin
    rsp_valid = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      rsp_valid[i] = vld_p1 && (owner_p1 == PTR_W'(i));
    end
  end

  assign rsp_result = result_p1;
  assign rsp_tag    = tag_p1;

endmodule

// File: tb/tb_kronos_alu_arb.sv
// Testbench for kronos_alu_arb: NUM_REQ=2 vector table plus a NUM_REQ=3 grant-order sequence.
module tb_kronos_alu_arb;

  localparam logic [3:0] ADD  = 4'h0;
  localparam logic [3:0] SUB  = 4'h8;
  localparam logic [3:0] XOR_ = 4'h4;
  localparam logic [3:0] OR_  = 4'h6;
  localparam logic [3:0] AND_ = 4'h7;

  logic clk = 1'b0;
  logic rstz;
  always #5 clk = ~clk;

  function automatic logic [31:0] alu_f(input logic [31:0] a, input logic [31:0] b,
                                         input logic [3:0] op);
    case (op)
      ADD:     return a + b;
      SUB:     return a - b;
      AND_:    return a & b;
      OR_:     return a | b;
      XOR_:    return a ^ b;
      default: return 32'd0;
    endcase
  endfunction

  // DUT A: two requesters
  logic [1:0]  a_req_valid, a_req_ready, a_rsp_valid, a_rsp_ready, a_rsp_tag;
  logic [63:0] a_op1, a_op2;
  logic [7:0]  a_aop;
  logic [3:0]  a_tag;
  logic [31:0] a_alu_op1, a_alu_op2, a_alu_res, a_rsp_result;
  logic [3:0]  a_alu_aop;

  assign a_alu_res = alu_f(a_alu_op1, a_alu_op2, a_alu_aop);

  kronos_alu_arb #(.NUM_REQ(2), .TAG_W(2)) dut_a (
    .clk(clk), .rstz(rstz),
    .req_valid(a_req_valid), .req_ready(a_req_ready),
    .req_op1(a_op1), .req_op2(a_op2), .req_aluop(a_aop), .req_tag(a_tag),
    .alu_op1(a_alu_op1), .alu_op2(a_alu_op2), .alu_aluop(a_alu_aop), .alu_result(a_alu_res),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready),
    .rsp_result(a_rsp_result), .rsp_tag(a_rsp_tag)
  );

  // DUT B: three requesters
  logic [2:0]  b_req_valid, b_req_ready, b_rsp_valid, b_rsp_ready;
  logic [1:0]  b_rsp_tag;
  logic [95:0] b_op1, b_op2;
  logic [11:0] b_aop;
  logic [5:0]  b_tag;
  logic [31:0] b_alu_op1, b_alu_op2, b_alu_res, b_rsp_result;
  logic [3:0]  b_alu_aop;

  assign b_alu_res = alu_f(b_alu_op1, b_alu_op2, b_alu_aop);

  kronos_alu_arb #(.NUM_REQ(3), .TAG_W(2)) dut_b (
    .clk(clk), .rstz(rstz),
    .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_op1(b_op1), .req_op2(b_op2), .req_aluop(b_aop), .req_tag(b_tag),
    .alu_op1(b_alu_op1), .alu_op2(b_alu_op2), .alu_aluop(b_alu_aop), .alu_result(b_alu_res),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_result(b_rsp_result), .rsp_tag(b_rsp_tag)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [1:0]  vld;
    logic [31:0] op1_0, op2_0;
    logic [3:0]  aop_0;
    logic [1:0]  tag_0;
    logic [31:0] op1_1, op2_1;
    logic [3:0]  aop_1;
    logic [1:0]  tag_1;
    logic [1:0]  rrdy;
    logic [1:0]  e_rdy;
    logic [31:0] e_aop1;
    logic [1:0]  e_rv;
    logic [31:0] e_res;
    logic [1:0]  e_tag;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(
    input logic [1:0] vld,
    input logic [31:0] o10, input logic [31:0] o20, input logic [3:0] a0, input logic [1:0] t0,
    input logic [31:0] o11, input logic [31:0] o21, input logic [3:0] a1, input logic [1:0] t1,
    input logic [1:0] rr, input logic [1:0] er, input logic [31:0] ea,
    input logic [1:0] erv, input logic [31:0] eres, input logic [1:0] et);
    vec_t v;
    v.vld = vld; v.op1_0 = o10; v.op2_0 = o20; v.aop_0 = a0; v.tag_0 = t0;
    v.op1_1 = o11; v.op2_1 = o21; v.aop_1 = a1; v.tag_1 = t1;
    v.rrdy = rr; v.e_rdy = er; v.e_aop1 = ea; v.e_rv = erv; v.e_res = eres; v.e_tag = et;
    return v;
  endfunction

  int exp_g[7];

  initial begin
    // single request, SUB 5-3
    vecs.push_back(mk(2'b01, 32'd5, 32'd3, SUB, 2'd1, 32'd0, 32'd0, ADD, 2'd0,
                      2'b11, 2'b01, 32'd5, 2'b01, 32'd2, 2'd1));
    // both valid: alternating grants
    vecs.push_back(mk(2'b11, 32'd10, 32'd4, ADD, 2'd2, 32'd20, 32'd5, SUB, 2'd3,
                      2'b11, 2'b10, 32'd20, 2'b10, 32'd15, 2'd3));
    vecs.push_back(mk(2'b11, 32'd10, 32'd4, ADD, 2'd2, 32'hF0, 32'h3C, AND_, 2'd0,
                      2'b11, 2'b01, 32'd10, 2'b01, 32'd14, 2'd2));
    vecs.push_back(mk(2'b11, 32'd1, 32'd2, ADD, 2'd1, 32'hF0, 32'h3C, AND_, 2'd0,
                      2'b11, 2'b10, 32'hF0, 2'b10, 32'h30, 2'd0));
    vecs.push_back(mk(2'b11, 32'hFF, 32'h0F, XOR_, 2'd3, 32'd1, 32'd1, OR_, 2'd1,
                      2'b11, 2'b01, 32'hFF, 2'b01, 32'hF0, 2'd3));
    // backpressure: req1 ADD 7+8, owner stalls 3 cycles while req0 waits
    vecs.push_back(mk(2'b10, 32'd0, 32'd0, ADD, 2'd0, 32'd7, 32'd8, ADD, 2'd2,
                      2'b11, 2'b10, 32'd7, 2'b10, 32'd15, 2'd2));
    for (int s = 0; s < 3; s++)
      vecs.push_back(mk(2'b01, 32'd100, 32'd1, SUB, 2'd1, 32'd0, 32'd0, ADD, 2'd0,
                        2'b01, 2'b00, 32'd100, 2'b10, 32'd15, 2'd2));
    vecs.push_back(mk(2'b01, 32'd100, 32'd1, SUB, 2'd1, 32'd0, 32'd0, ADD, 2'd0,
                      2'b10, 2'b01, 32'd100, 2'b01, 32'd99, 2'd1));
    // non-owner ready ignored, idle drive is zero
    vecs.push_back(mk(2'b00, 32'd0, 32'd0, ADD, 2'd0, 32'd0, 32'd0, ADD, 2'd0,
                      2'b10, 2'b00, 32'd0, 2'b01, 32'd99, 2'd1));
    vecs.push_back(mk(2'b00, 32'd0, 32'd0, ADD, 2'd0, 32'd0, 32'd0, ADD, 2'd0,
                      2'b00, 2'b00, 32'd0, 2'b01, 32'd99, 2'd1));
    // drain without refill holds result/tag
    vecs.push_back(mk(2'b00, 32'd0, 32'd0, ADD, 2'd0, 32'd0, 32'd0, ADD, 2'd0,
                      2'b01, 2'b00, 32'd0, 2'b00, 32'd99, 2'd1));
    vecs.push_back(mk(2'b01, 32'd3, 32'd3, SUB, 2'd0, 32'd0, 32'd0, ADD, 2'd0,
                      2'b00, 2'b01, 32'd3, 2'b01, 32'd0, 2'd0));
    // idle cycles did not move rr_ptr: req1 still wins
    vecs.push_back(mk(2'b11, 32'd50, 32'd1, ADD, 2'd1, 32'd2, 32'd2, ADD, 2'd3,
                      2'b01, 2'b10, 32'd2, 2'b10, 32'd4, 2'd3));
    vecs.push_back(mk(2'b01, 32'd9, 32'd1, SUB, 2'd1, 32'd0, 32'd0, ADD, 2'd0,
                      2'b10, 2'b01, 32'd9, 2'b01, 32'd8, 2'd1));

`ifdef KRONOS_ALU_ARB_PRIO_EN
    exp_g = '{0, 0, 0, 0, 1, 2, 1};
`else
    exp_g = '{0, 1, 2, 0, 1, 2, 1};
`endif

    rstz = 1'b0;
    a_req_valid = 2'b11; a_op1 = '0; a_op2 = '0; a_aop = '0; a_tag = '0; a_rsp_ready = 2'b11;
    b_req_valid = '0; b_op1 = '0; b_op2 = '0; b_aop = '0; b_tag = '0; b_rsp_ready = 3'b111;

    #12;
    chk("reset_rdy", 32'(a_req_ready), 32'd0);
    chk("reset_rv", 32'(a_rsp_valid), 32'd0);
    chk("reset_res", a_rsp_result, 32'd0);
    chk("reset_tag", 32'(a_rsp_tag), 32'd0);
    @(negedge clk) rstz = 1'b1;
    #1 chk("first_cycle_rdy", 32'(a_req_ready), 32'd0);
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      a_req_valid = vecs[i].vld;
      a_op1 = {vecs[i].op1_1, vecs[i].op1_0};
      a_op2 = {vecs[i].op2_1, vecs[i].op2_0};
      a_aop = {vecs[i].aop_1, vecs[i].aop_0};
      a_tag = {vecs[i].tag_1, vecs[i].tag_0};
      a_rsp_ready = vecs[i].rrdy;
      #8;
      chk($sformatf("v%0d_rdy", i), 32'(a_req_ready), 32'(vecs[i].e_rdy));
      chk($sformatf("v%0d_alu_op1", i), a_alu_op1, vecs[i].e_aop1);
      @(posedge clk); #1;
      chk($sformatf("v%0d_rsp_valid", i), 32'(a_rsp_valid), 32'(vecs[i].e_rv));
      chk($sformatf("v%0d_rsp_result", i), a_rsp_result, vecs[i].e_res);
      chk($sformatf("v%0d_rsp_tag", i), 32'(a_rsp_tag), 32'(vecs[i].e_tag));
    end

    // asynchronous reset with a full response and rr_ptr=1
    a_req_valid = 2'b11; a_rsp_ready = 2'b00;
    #3 rstz = 1'b0;
    #1;
    chk("async_rst_rv", 32'(a_rsp_valid), 32'd0);
    chk("async_rst_res", a_rsp_result, 32'd0);
    chk("async_rst_rdy", 32'(a_req_ready), 32'd0);
    @(posedge clk); #1;
    chk("rst_hold_rv", 32'(a_rsp_valid), 32'd0);
    @(negedge clk) rstz = 1'b1;
    #1 chk("rel_first_rdy", 32'(a_req_ready), 32'd0);
    @(posedge clk); #7;
    chk("rr_after_rst", 32'(a_req_ready), 32'b01);
    @(posedge clk); #1;
    a_req_valid = 2'b00;

    // NUM_REQ=3 grant order
    for (int c = 0; c < 7; c++) begin
      b_req_valid = (c < 4) ? 3'b111 : 3'b110;
      for (int k = 0; k < 3; k++) begin
        b_op1[32*k +: 32] = 32'(k * 100);
        b_op2[32*k +: 32] = 32'(c);
        b_aop[4*k +: 4]   = ADD;
        b_tag[2*k +: 2]   = 2'(k);
      end
      #8;
      chk($sformatf("b%0d_rdy", c), 32'(b_req_ready), 32'(3'b001 << exp_g[c]));
      @(posedge clk); #1;
      chk($sformatf("b%0d_rsp_valid", c), 32'(b_rsp_valid), 32'(3'b001 << exp_g[c]));
      chk($sformatf("b%0d_rsp_result", c), b_rsp_result, 32'(exp_g[c] * 100 + c));
      chk($sformatf("b%0d_rsp_tag", c), 32'(b_rsp_tag), 32'(exp_g[c]));
    end
    b_req_valid = '0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
